// File: rtl/seq_div_ctrl_if.sv
// Requester handshake and shared add/sub datapath signals for the sequential divider.
// slave = divider controller, master = requester plus the attached add/sub unit.
interface seq_div_ctrl_if #(
    parameter int unsigned WIDTH = 4
);
    // requester side
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    // add/sub datapath side
    logic [WIDTH-1:0] as_a;
    logic [WIDTH-1:0] as_b;
    logic             as_ctrl;
    logic [WIDTH-1:0] as_s;
    logic             as_cout;

    modport slave (
        input  start, dividend, divisor, as_s, as_cout,
        output busy, done, quotient, remainder, div_by_zero,
        output as_a, as_b, as_ctrl
    );

    modport master (
        output start, dividend, divisor, as_s, as_cout,
        input  busy, done, quotient, remainder, div_by_zero,
        input  as_a, as_b, as_ctrl
    );
endinterface

// File: rtl/seq_div_ctrl.sv
// Restoring divider controller: one trial subtraction per cycle on an external add/sub unit.
// Produces quotient/remainder after WIDTH iterations; divisor 0 short-circuits to DONE.
module seq_div_ctrl #(
    parameter int unsigned WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    seq_div_ctrl_if.slave      bus
);
    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dsr;
    logic [CW-1:0]    r_cnt;

    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_div_by_zero;

    logic [WIDTH-1:0] w_trial;
    logic             w_msb;
    logic             w_accept;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_quo_next;
    logic             w_last;

    // Shift next dividend bit into the partial remainder; a set msb means the
    // shifted value already exceeds any WIDTH-bit divisor, so the subtraction is taken.
    assign w_trial    = {r_rem[WIDTH-2:0], r_quo[WIDTH-1]};
    assign w_msb      = r_rem[WIDTH-1];
    assign w_accept   = bus.as_cout | w_msb;
    assign w_rem_next = w_accept ? bus.as_s : w_trial;
    assign w_quo_next = {r_quo[WIDTH-2:0], w_accept};
    assign w_last     = (r_cnt == CW'(WIDTH - 1));

    // Add/sub operands come from registered state only.
    always_comb begin
        bus.as_a    = '0;
        bus.as_b    = '0;
        bus.as_ctrl = 1'b0;
        if (r_state == S_ITER) begin
            bus.as_a    = w_trial;
            bus.as_b    = r_dsr;
            bus.as_ctrl = 1'b1;
        end
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_rem         <= '0;
            r_quo         <= '0;
            r_dsr         <= '0;
            r_cnt         <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_quotient    <= '0;
            r_remainder   <= '0;
            r_div_by_zero <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        if (bus.divisor == '0) begin
                            r_quotient    <= '1;
                            r_remainder   <= bus.dividend;
                            r_div_by_zero <= 1'b1;
                            r_done        <= 1'b1;
                            r_busy        <= 1'b1;
                            r_state       <= S_DONE;
                        end else begin
                            r_rem   <= '0;
                            r_quo   <= bus.dividend;
                            r_dsr   <= bus.divisor;
                            r_cnt   <= '0;
                            r_busy  <= 1'b1;
                            r_state <= S_ITER;
                        end
                    end
                end
                S_ITER: begin
                    r_rem <= w_rem_next;
                    r_quo <= w_quo_next;
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_quotient    <= w_quo_next;
                        r_remainder   <= w_rem_next;
                        r_div_by_zero <= 1'b0;
                        r_done        <= 1'b1;
                        r_state       <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.quotient    = r_quotient;
    assign bus.remainder   = r_remainder;
    assign bus.div_by_zero = r_div_by_zero;
endmodule

// File: tb/tb_seq_div_ctrl.sv
// Directed and exhaustive checks of seq_div_ctrl (WIDTH=4) with a ripple add/sub attached.
module tb_seq_div_ctrl;
    localparam int unsigned W = 4;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    seq_div_ctrl_if #(.WIDTH(W)) bus ();

    seq_div_ctrl #(.WIDTH(W)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Ripple add/sub unit: ctrl=1 computes a + ~b + 1.
    always_comb begin
        logic [W:0]   c;
        logic [W-1:0] bb;
        bb   = bus.as_ctrl ? ~bus.as_b : bus.as_b;
        c    = '0;
        c[0] = bus.as_ctrl;
        bus.as_s = '0;
        for (int i = 0; i < int'(W); i++) begin
            bus.as_s[i] = bus.as_a[i] ^ bb[i] ^ c[i];
            c[i+1]      = (bus.as_a[i] & bb[i]) | (c[i] & (bus.as_a[i] ^ bb[i]));
        end
        bus.as_cout = c[W];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One division; inj>0 pulses start with 9/2 in that cycle to check it is ignored.
    task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] eq, input logic [W-1:0] er, input logic ez,
                           input int elat, input int inj);
        int lat   = 0;
        int nctrl = 0;
        bit seen  = 0;
        logic busy_at_done = 1'b0;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        for (int c = 1; c <= 20 && !seen; c++) begin
            @(negedge clk);
            bus.start = (c == inj);
            if (c == inj) begin
                bus.dividend = 4'd9;
                bus.divisor  = 4'd2;
            end
            if (bus.as_ctrl) nctrl++;
            if (bus.done) begin
                seen = 1;
                lat  = c;
                busy_at_done = bus.busy;
            end
        end
        bus.start = 1'b0;
        check($sformatf("lat %0d/%0d", a, b), lat, elat);
        check($sformatf("quo %0d/%0d", a, b), bus.quotient, eq);
        check($sformatf("rem %0d/%0d", a, b), bus.remainder, er);
        check($sformatf("dbz %0d/%0d", a, b), bus.div_by_zero, ez);
        check($sformatf("ctrl %0d/%0d", a, b), nctrl, ez ? 0 : W);
        check($sformatf("busy_done %0d/%0d", a, b), busy_at_done, 1);
        @(negedge clk);
        check($sformatf("done_pulse %0d/%0d", a, b), bus.done, 0);
        check($sformatf("idle_busy %0d/%0d", a, b), bus.busy, 0);
    endtask

    initial begin
        int d1, d2, d3, nd;
        n_tests      = 0;
        n_fail       = 0;
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_quo", bus.quotient, 0);
        check("rst_rem", bus.remainder, 0);
        check("rst_dbz", bus.div_by_zero, 0);
        check("rst_asctrl", bus.as_ctrl, 0);
        rst = 1'b0;

        run_div(4'd13, 4'd3,  4'd4,  4'd1, 1'b0, 5, 0);
        run_div(4'd15, 4'd2,  4'd7,  4'd1, 1'b0, 5, 0);
        run_div(4'd8,  4'd1,  4'd8,  4'd0, 1'b0, 5, 0);
        run_div(4'd15, 4'd15, 4'd1,  4'd0, 1'b0, 5, 0);
        run_div(4'd3,  4'd7,  4'd0,  4'd3, 1'b0, 5, 0);
        run_div(4'd5,  4'd0,  4'd15, 4'd5, 1'b1, 1, 0);
        run_div(4'd6,  4'd3,  4'd2,  4'd0, 1'b0, 5, 0);
        run_div(4'd13, 4'd3,  4'd4,  4'd1, 1'b0, 5, 2);

        // start held high: one result every WIDTH+2 cycles
        d1 = 0; d2 = 0; d3 = 0; nd = 0;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 4'd7;
        bus.divisor  = 4'd2;
        for (int c = 1; c <= 17; c++) begin
            @(negedge clk);
            if (bus.done) begin
                nd++;
                if (nd == 1) d1 = c;
                if (nd == 2) d2 = c;
                if (nd == 3) d3 = c;
                check("b2b_quo", bus.quotient, 3);
                check("b2b_rem", bus.remainder, 1);
            end
        end
        bus.start = 1'b0;
        check("b2b_count", nd, 3);
        check("b2b_first", d1, 5);
        check("b2b_gap1", d2 - d1, 6);
        check("b2b_gap2", d3 - d2, 6);
        repeat (2) @(negedge clk);

        // reset in the second ITER cycle aborts without done
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 4'd13;
        bus.divisor  = 4'd3;
        @(negedge clk);
        bus.start = 1'b0;
        check("abort_busy_pre", bus.busy, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        check("abort_quo", bus.quotient, 0);
        check("abort_rem", bus.remainder, 0);
        check("abort_dbz", bus.div_by_zero, 0);
        rst = 1'b0;
        nd  = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bus.done) nd++;
        end
        check("abort_nodone", nd, 0);
        run_div(4'd14, 4'd4, 4'd3, 4'd2, 1'b0, 5, 0);

        // exhaustive sweep against a behavioural model
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                logic [W-1:0] eq, er;
                logic         ez;
                ez = (b == 0);
                eq = ez ? 4'd15 : W'(a / b);
                er = ez ? W'(a) : W'(a % b);
                run_div(W'(a), W'(b), eq, er, ez, ez ? 1 : 5, 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
